// File: rtl/axi_traffic_master.sv
// rtl/axi_traffic_master.sv - AXI3 write-then-readback traffic master with LFSR data and lane checking
module axi_traffic_master #(
    parameter int ID_WIDTH        = 10,
    parameter int ADDR_WIDTH      = 32,
    parameter int LEN_WIDTH       = 8,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TXN_ID          = 0,
    parameter int THROTTLE_EN     = 1
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   cfg_base,
    input  logic [7:0]              cfg_num,
    input  logic [LEN_WIDTH-1:0]    cfg_len,
    input  logic [2:0]              cfg_size,
    input  logic [1:0]              cfg_burst,
    input  logic [31:0]             cfg_seed,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [15:0]             err_cnt,
    output logic [ADDR_WIDTH-1:0]   err_addr,
    output logic                    resp_err,
    output logic [ID_WIDTH-1:0]     m_awid,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [LEN_WIDTH-1:0]    m_awlen,
    output logic [2:0]              m_awsize,
    output logic [1:0]              m_awburst,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [ID_WIDTH-1:0]     m_wid,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wlast,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [ID_WIDTH-1:0]     m_bid,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    output logic [ID_WIDTH-1:0]     m_arid,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [LEN_WIDTH-1:0]    m_arlen,
    output logic [2:0]              m_arsize,
    output logic [1:0]              m_arburst,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    input  logic [ID_WIDTH-1:0]     m_rid,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rlast,
    input  logic                    m_rvalid,
    output logic                    m_rready
);
    localparam int STRB_W    = DATA_WIDTH / 8;
    localparam int LANE_BITS = $clog2(STRB_W);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_WDRAIN, S_RD, S_RDRAIN} state_t;
    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] c_base, step, aw_addr, w_burst_addr, ar_addr, r_burst_addr;
    logic [7:0]            c_num, aw_cnt, b_cnt, w_burst, ar_cnt, r_burst;
    logic [LEN_WIDTH-1:0]  c_len, w_beat, r_beat;
    logic [2:0]            c_size, thr;
    logic [1:0]            c_burst;
    logic [31:0]           c_seed, w_lfsr, chk_lfsr;
    logic                  done_q, pass_q, resp_err_q, err_seen;
    logic [15:0]           err_cnt_q;
    logic [ADDR_WIDTH-1:0] err_addr_q;

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return {1'b0, v[31:1]} ^ (v[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    // First beat is aligned down to the transfer size; FIXED bursts never advance.
    function automatic logic [ADDR_WIDTH-1:0] beat_addr_f(input logic [ADDR_WIDTH-1:0] base,
                                                          input logic [LEN_WIDTH-1:0] beat,
                                                          input logic [2:0] size,
                                                          input logic fixed);
        logic [ADDR_WIDTH-1:0] unit;
        unit = ADDR_WIDTH'(1) << size;
        return (base & ~(unit - 1'b1)) + (fixed ? '0 : (ADDR_WIDTH'(beat) << size));
    endfunction

    function automatic logic [STRB_W-1:0] strb_f(input logic [LANE_BITS-1:0] off, input logic [2:0] size);
        logic [STRB_W:0]       ones;
        logic [2*STRB_W-1:0]   wide;
        ones = ((STRB_W+1)'(1) << (1 << size)) - 1'b1;
        wide = (2*STRB_W)'(ones) << off;
        return wide[STRB_W-1:0];
    endfunction

    logic                  c_fixed, cfg_ok, aw_hs, w_hs, b_hs, ar_hs, r_hs, rlast_err, run_end;
    logic [7:0]            outstanding;
    logic [ADDR_WIDTH-1:0] w_beat_addr, r_beat_addr;
    logic [STRB_W-1:0]     w_strb, r_strb;
    logic [DATA_WIDTH-1:0] w_rep, exp_data;
    logic [15:0]           mism;
    logic [16:0]           err_sum;

    assign c_fixed     = (c_burst == 2'b00);
    assign cfg_ok      = (cfg_num != 8'd0) && !cfg_burst[1] && (cfg_size <= 3'(LANE_BITS));
    assign outstanding = aw_cnt - b_cnt;
    assign w_beat_addr = beat_addr_f(w_burst_addr, w_beat, c_size, c_fixed);
    assign r_beat_addr = beat_addr_f(r_burst_addr, r_beat, c_size, c_fixed);
    assign w_strb      = strb_f(w_beat_addr[LANE_BITS-1:0], c_size);
    assign r_strb      = strb_f(r_beat_addr[LANE_BITS-1:0], c_size);
    assign w_rep       = {(DATA_WIDTH/32){w_lfsr}};
    assign exp_data    = {(DATA_WIDTH/32){chk_lfsr}};

    assign m_awvalid = (state == S_WR) && (aw_cnt != c_num) && (outstanding < 8'(MAX_OUTSTANDING));
    assign m_wvalid  = (state == S_WR) && (w_burst != c_num);
    assign m_arvalid = (state == S_RD) && (ar_cnt != c_num);
    assign m_bready  = (THROTTLE_EN == 0) || thr[0] || thr[1];
    assign m_rready  = m_bready;

    assign aw_hs = m_awvalid && m_awready;
    assign w_hs  = m_wvalid && m_wready;
    assign ar_hs = m_arvalid && m_arready;
    assign b_hs  = m_bvalid && m_bready && ((state == S_WR) || (state == S_WDRAIN));
    assign r_hs  = m_rvalid && m_rready && ((state == S_RD) || (state == S_RDRAIN));
    assign rlast_err = m_rlast != (r_beat == c_len);
    assign run_end   = (state == S_RDRAIN) && (r_burst == c_num);

    always_comb begin
        m_wdata = '0;
        mism    = '0;
        for (int i = 0; i < STRB_W; i++) begin
            if (w_strb[i] && m_wvalid)
                m_wdata[8*i +: 8] = w_rep[8*i +: 8];
            if (r_strb[i] && (m_rdata[8*i +: 8] != exp_data[8*i +: 8]))
                mism = mism + 16'd1;
        end
        err_sum = {1'b0, err_cnt_q} + {1'b0, mism} + {16'd0, rlast_err};
    end

    assign m_wstrb   = m_wvalid ? w_strb : '0;
    assign m_wlast   = m_wvalid && (w_beat == c_len);
    assign m_awid    = ID_WIDTH'(TXN_ID);
    assign m_wid     = ID_WIDTH'(TXN_ID);
    assign m_arid    = ID_WIDTH'(TXN_ID);
    assign m_awaddr  = aw_addr;
    assign m_araddr  = ar_addr;
    assign m_awlen   = c_len;
    assign m_arlen   = c_len;
    assign m_awsize  = c_size;
    assign m_arsize  = c_size;
    assign m_awburst = c_burst;
    assign m_arburst = c_burst;
    assign busy      = (state != S_IDLE);
    assign done      = done_q;
    assign pass      = pass_q;
    assign resp_err  = resp_err_q;
    assign err_cnt   = err_cnt_q;
    assign err_addr  = err_addr_q;

    always_ff @(posedge aclk) begin
        if (!aresetn) state <= S_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start && cfg_ok) state_next = S_WR;
            S_WR:     if ((aw_cnt == c_num) && (w_burst == c_num)) state_next = S_WDRAIN;
            S_WDRAIN: if (b_cnt == c_num) state_next = S_RD;
            S_RD:     if (ar_cnt == c_num) state_next = S_RDRAIN;
            S_RDRAIN: if (run_end) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            c_base <= '0; step <= '0; aw_addr <= '0; w_burst_addr <= '0; ar_addr <= '0; r_burst_addr <= '0;
            c_num <= '0; aw_cnt <= '0; b_cnt <= '0; w_burst <= '0; ar_cnt <= '0; r_burst <= '0;
            c_len <= '0; w_beat <= '0; r_beat <= '0; c_size <= '0; c_burst <= '0; thr <= 3'b001;
            c_seed <= 32'h1; w_lfsr <= 32'h1; chk_lfsr <= 32'h1;
            done_q <= 1'b0; pass_q <= 1'b0; resp_err_q <= 1'b0; err_seen <= 1'b0;
            err_cnt_q <= '0; err_addr_q <= '0;
        end else begin
            thr    <= {1'b0, thr[2:1]} ^ (thr[0] ? 3'b110 : 3'b000);
            done_q <= 1'b0;
            if ((state == S_IDLE) && start) begin
                pass_q <= 1'b0; err_cnt_q <= '0; err_addr_q <= '0; err_seen <= 1'b0;
                if (cfg_ok) begin
                    resp_err_q <= 1'b0;
                    c_base <= cfg_base; c_num <= cfg_num; c_len <= cfg_len;
                    c_size <= cfg_size; c_burst <= cfg_burst;
                    c_seed <= (cfg_seed == 32'h0) ? 32'h1 : cfg_seed;
                    w_lfsr <= (cfg_seed == 32'h0) ? 32'h1 : cfg_seed;
                    step   <= (cfg_burst == 2'b00) ? (ADDR_WIDTH'(1) << cfg_size)
                                                   : ((ADDR_WIDTH'(cfg_len) + 1'b1) << cfg_size);
                    aw_addr <= cfg_base; w_burst_addr <= cfg_base;
                    aw_cnt <= '0; b_cnt <= '0; w_burst <= '0; w_beat <= '0;
                    ar_cnt <= '0; r_burst <= '0; r_beat <= '0;
                end else begin
                    done_q <= 1'b1; resp_err_q <= 1'b1;
                end
            end
            if (aw_hs) begin
                aw_cnt  <= aw_cnt + 8'd1;
                aw_addr <= aw_addr + step;
            end
            if (w_hs) begin
                w_lfsr <= lfsr_next(w_lfsr);
                if (m_wlast) begin
                    w_beat <= '0; w_burst <= w_burst + 8'd1; w_burst_addr <= w_burst_addr + step;
                end else begin
                    w_beat <= w_beat + 1'b1;
                end
            end
            if (b_hs) begin
                b_cnt <= b_cnt + 8'd1;
                if ((m_bresp != 2'b00) || (m_bid != ID_WIDTH'(TXN_ID))) resp_err_q <= 1'b1;
            end
            // Readback replays the write sequence from the same seed and base.
            if ((state == S_WDRAIN) && (b_cnt == c_num)) begin
                chk_lfsr <= c_seed; ar_addr <= c_base; r_burst_addr <= c_base;
            end
            if (ar_hs) begin
                ar_cnt  <= ar_cnt + 8'd1;
                ar_addr <= ar_addr + step;
            end
            if (r_hs) begin
                chk_lfsr  <= lfsr_next(chk_lfsr);
                err_cnt_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
                if ((m_rresp != 2'b00) || (m_rid != ID_WIDTH'(TXN_ID))) resp_err_q <= 1'b1;
                if ((mism != 16'd0) && !err_seen) begin
                    err_seen <= 1'b1; err_addr_q <= r_beat_addr;
                end
                if (m_rlast) begin
                    r_beat <= '0; r_burst <= r_burst + 8'd1; r_burst_addr <= r_burst_addr + step;
                end else begin
                    r_beat <= r_beat + 1'b1;
                end
            end
            if (run_end) begin
                done_q <= 1'b1;
                pass_q <= (err_cnt_q == 16'd0) && !resp_err_q;
            end
        end
    end
endmodule
